// File: rtl/sha_pkg.sv
// Shared FSM encoding, digest geometry and default address map for the SHA
// memory responder.
package sha_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_DRAIN
    } state_e;

    localparam int          DIG_WORDS    = 8;
    localparam logic [15:0] DEF_MSG_ADDR = 16'h0000;
    localparam logic [15:0] DEF_OUT_ADDR = 16'h0080;

    // True when addr falls inside the DIG_WORDS-long digest window at base.
    function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base);
        return (addr >= base) && ({1'b0, addr} < ({1'b0, base} + 17'(DIG_WORDS)));
    endfunction

endpackage

// File: rtl/sha_mem_responder_if.sv
// Host, core, core-memory, digest-stream and status signals of the responder,
// seen from the responder (slave) and from whatever drives it (master).
interface sha_mem_responder_if;

    logic        host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic        go;

    logic        core_start;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic        core_done;

    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic        dig_valid;
    logic        dig_ready;
    logic [31:0] dig_data;
    logic        dig_last;

    logic        busy;
    logic        timeout_err;
    logic        range_err;

    modport slave (
        input  host_we, host_addr, host_wdata, go,
        input  core_done, mem_we, mem_addr, mem_write_data, dig_ready,
        output core_start, message_addr, output_addr, mem_read_data,
        output dig_valid, dig_data, dig_last, busy, timeout_err, range_err
    );

    modport master (
        output host_we, host_addr, host_wdata, go,
        output core_done, mem_we, mem_addr, mem_write_data, dig_ready,
        input  core_start, message_addr, output_addr, mem_read_data,
        input  dig_valid, dig_data, dig_last, busy, timeout_err, range_err
    );

endinterface

// File: rtl/sha_word_ram.sv
// Word-wide storage: one write port, one registered read port with read enable
// so the last read word stays on rdata_o while re_i is low.
module sha_word_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // NOTE: storage and its read register are deliberately left out of reset;
    // contents must survive reset and this keeps the array mappable to RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sha_mem_responder.sv
// Memory-side companion of a SHA core: host loads the message, the core runs
// against the shared RAM, and the 8-word digest is streamed out afterwards.
module sha_mem_responder
    import sha_pkg::*;
#(
    parameter int          DEPTH    = 256,
    parameter logic [15:0] MSG_ADDR = DEF_MSG_ADDR,
    parameter logic [15:0] OUT_ADDR = DEF_OUT_ADDR,
    parameter int          TIMEOUT  = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_clk,
    sha_mem_responder_if.slave bus
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [16:0]     DEPTH_L  = 17'(DEPTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    if (int'(OUT_ADDR) + DIG_WORDS - 1 > 65535) begin : g_out_addr_check
        $error("OUT_ADDR digest window wraps past 16'hFFFF");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [3:0]    drain_cnt_q, drain_cnt_d;
    logic          dig_valid_q, dig_valid_d;
    logic          dig_last_q, dig_last_d;
    logic          timeout_err_q, timeout_err_d;
    logic          range_err_q, range_err_d;
    logic          core_rd_q;
    logic          rd_ok_q;

    logic          core_phase;
    logic          drain_issue;
    logic          ram_wreq, ram_we, ram_re;
    logic [15:0]   ram_waddr, ram_raddr;
    logic [31:0]   ram_wdata, ram_rdata;
    logic          unused_mem_clk;

    assign unused_mem_clk = mem_clk;

    function automatic logic in_depth(input logic [15:0] addr);
        return {1'b0, addr} < DEPTH_L;
    endfunction

    assign core_phase  = (state_q == ST_START) || (state_q == ST_WAIT_LO) ||
                         (state_q == ST_WAIT_HI);
    // Fetch the next digest word at entry and whenever the held word is taken.
    assign drain_issue = (state_q == ST_DRAIN) && (!dig_valid_q || bus.dig_ready) &&
                         (drain_cnt_q < 4'(DIG_WORDS));

    // NOTE: every combinational output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        ram_wreq  = 1'b0;
        ram_waddr = bus.mem_addr;
        ram_wdata = bus.mem_write_data;
        ram_re    = 1'b0;
        ram_raddr = bus.mem_addr;
        if (state_q == ST_IDLE) begin
            ram_wreq  = bus.host_we;
            ram_waddr = bus.host_addr;
            ram_wdata = bus.host_wdata;
        end else if (core_phase) begin
            ram_wreq  = bus.mem_we;
            ram_re    = 1'b1;
        end else begin
            ram_re    = drain_issue;
            ram_raddr = OUT_ADDR + 16'(drain_cnt_q);
        end
    end

    assign ram_we = ram_wreq && in_depth(ram_waddr);

    sha_word_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr[AW-1:0]),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (ram_raddr[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d       = state_q;
        cyc_cnt_d     = cyc_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        dig_valid_d   = dig_valid_q;
        dig_last_d    = dig_last_q;
        timeout_err_d = timeout_err_q;
        range_err_d   = range_err_q;

        if (core_phase) begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
            if (bus.mem_we && !in_window(bus.mem_addr, OUT_ADDR)) begin
                range_err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                cyc_cnt_d   = '0;
                drain_cnt_d = '0;
                if (bus.go) begin
                    state_d       = ST_START;
                    timeout_err_d = 1'b0;
                    range_err_d   = 1'b0;
                end
            end
            ST_START:   state_d = ST_WAIT_LO;
            ST_WAIT_LO: if (!bus.core_done) state_d = ST_WAIT_HI;
            ST_WAIT_HI: if (bus.core_done) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (drain_issue) begin
                    drain_cnt_d = drain_cnt_q + 4'd1;
                    dig_valid_d = 1'b1;
                    dig_last_d  = (drain_cnt_q == 4'(DIG_WORDS - 1));
                end else if (dig_valid_q && bus.dig_ready) begin
                    dig_valid_d = 1'b0;
                    dig_last_d  = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A done arriving on the final budgeted cycle still counts as in time.
        if (core_phase && (cyc_cnt_q == CNT_LAST) && (state_d != ST_DRAIN)) begin
            state_d       = ST_IDLE;
            timeout_err_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cyc_cnt_q     <= '0;
            drain_cnt_q   <= '0;
            dig_valid_q   <= 1'b0;
            dig_last_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            range_err_q   <= 1'b0;
            core_rd_q     <= 1'b0;
            rd_ok_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cyc_cnt_q     <= cyc_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            dig_valid_q   <= dig_valid_d;
            dig_last_q    <= dig_last_d;
            timeout_err_q <= timeout_err_d;
            range_err_q   <= range_err_d;
            core_rd_q     <= core_phase;
            if (ram_re) begin
                rd_ok_q <= in_depth(ram_raddr);
            end
        end
    end

    assign bus.core_start    = (state_q == ST_START);
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.message_addr  = MSG_ADDR;
    assign bus.output_addr   = OUT_ADDR;
    assign bus.mem_read_data = (core_rd_q && rd_ok_q) ? ram_rdata : 32'h0;
    assign bus.dig_valid     = dig_valid_q;
    assign bus.dig_last      = dig_last_q;
    assign bus.dig_data      = (dig_valid_q && rd_ok_q) ? ram_rdata : 32'h0;
    assign bus.timeout_err   = timeout_err_q;
    assign bus.range_err     = range_err_q;

endmodule
